// File: rtl/mult_defs.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Optional feature macro used by the top level: EARLY_TERM_EN.
package mult_defs;

  // Default operand width; the product is twice this wide.
  localparam int MULT_WIDTH = 4;

  // Iteration counter width for the default operand width.
  localparam int CNT_W = $clog2(MULT_WIDTH);

  // FSM encoding; debug tooling relies on these exact values.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width, never below one bit.
  function automatic int cnt_width(input int w);
    int cw;
    cw = $clog2(w);
    if (cw < 1) cw = 1;
    return cw;
  endfunction

endpackage

// File: rtl/seq_mult_4x4_rca_nbit.sv
// Ripple-carry adder built from the shared 1-bit full-adder cell.
// Carry-in is fixed at zero; the carry-out feeds the accumulator MSB.

// 1-bit full-adder cell.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  // Sum and majority carry.
  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// WIDTH-bit ripple-carry adder.
module rca_nbit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    fa_cell u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/seq_mult_4x4.sv
// Sequential shift-and-add unsigned multiplier, one partial-product add per clock.
// Optional macro EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
//
// Handshake: Start is a request qualified by Busy=0 (IDLE or DONE). A Start seen while
// Busy=1 is dropped without effect. Done is a one-cycle valid for P; there is no
// back-pressure, and P holds its value until the next operation's final iteration.
module seq_mult_4x4
  import mult_defs::*;
#(
  parameter int WIDTH = MULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               Busy,
  output logic               Done,
  output logic [2*WIDTH-1:0] P,
  output state_t             dbg_state
);

  localparam int CW = cnt_width(WIDTH);
  localparam int PW = 2 * WIDTH;

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] mcand_q;
  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    p_q;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic [PW-1:0]    acc_step;
  logic [PW-1:0]    acc_next;
  logic             early;
  logic             last_iter;
  logic             accept;

  // Partial product: multiplicand when the current multiplier bit is set.
  assign addend = acc_q[0] ? mcand_q : '0;

  rca_nbit #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a    (acc_q[PW-1:WIDTH]),
    .b    (addend),
    .sum  (sum),
    .cout (carry)
  );

  // One shift-and-add step: carry lands in the MSB, consumed multiplier bit drops out.
  assign acc_step = {carry, sum, acc_q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
  logic [WIDTH-1:0] mask;

  // Zero-detect on the multiplier bits not yet consumed after this step; if all
  // are zero the remaining shifts add nothing and are folded into this cycle.
  always_comb begin
    mask     = ({WIDTH{1'b1}} >> cnt_q) & {{(WIDTH-1){1'b1}}, 1'b0};
    early    = ((acc_q[WIDTH-1:0] & mask) == '0);
    acc_next = acc_step;
    if (early) begin
      acc_next = acc_step >> (WIDTH - 1 - int'(cnt_q));
    end
  end
`else
  // Fixed-latency build: every operation takes exactly WIDTH iterations.
  always_comb begin
    early    = 1'b0;
    acc_next = acc_step;
  end
`endif

  assign last_iter = (cnt_q == CW'(WIDTH - 1)) || early;

  // State register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and operand acceptance.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (last_iter) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (Start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath registers: operand capture, iteration, and product load on the final step.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else if (accept) begin
      cnt_q   <= '0;
      mcand_q <= A;
      acc_q   <= {{WIDTH{1'b0}}, B};
    end else if (state_q == ST_RUN) begin
      cnt_q <= cnt_q + CW'(1);
      acc_q <= acc_next;
      if (last_iter) begin
        p_q <= acc_next;
      end
    end
  end

  // Status outputs decoded from the state register.
  always_comb begin
    Busy      = (state_q == ST_RUN);
    Done      = (state_q == ST_DONE);
    P         = p_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_seq_mult_4x4.sv
// Testbench for seq_mult_4x4: directed steps plus a shuffled exhaustive sweep and
// randomized back-to-back chains, checked against an arithmetic reference model.
module tb_seq_mult_4x4;
  import mult_defs::*;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          Clk;
  logic          Rst_n;
  logic          Start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          Busy;
  logic          Done;
  logic [PW-1:0] P;
  state_t        dbg_state;

  int vectors;
  int miscompares;
  logic [PW-1:0] exp_q[$];

  seq_mult_4x4 #(
    .WIDTH (W)
  ) dut (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .Start     (Start),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .P         (P),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Reference model: latency from the multiplier value alone.
  function automatic int exp_lat(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
    int h;
    h = 0;
    for (int i = 0; i < W; i++) begin
      if (b[i]) h = i;
    end
    return h + 1;
`else
    return W;
`endif
  endfunction

  // Scoreboard push: expected product by plain arithmetic.
  task automatic push_exp(input logic [W-1:0] a, input logic [W-1:0] b);
    int prod;
    prod = int'(a) * int'(b);
    exp_q.push_back(PW'(prod));
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for Done, counting clock edges since the accepting edge (lat0 already elapsed).
  // Returns at the falling edge inside the Done cycle.
  task automatic wait_done(input string tag, input int elat, input int lat0);
    int lat;
    bit seen;
    logic [PW-1:0] exp;
    lat  = lat0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge Clk);
      if (Done === 1'b1) begin
        seen = 1'b1;
      end else begin
        @(posedge Clk);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    chk({tag, "_busy_on_done"}, 32'(Busy), 32'd0);
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
    end else begin
      exp = '1;
    end
    chk({tag, "_product"}, 32'(P), 32'(exp));
  endtask

  // Single operation with Start pulsed for one accepted edge.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge Clk);
    Start = 1'b1;
    A     = a;
    B     = b;
    push_exp(a, b);
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done(tag, exp_lat(b), 0);
  endtask

  // Observe n cycles and require that no Done pulse appears.
  task automatic no_done(input string tag, input int n);
    bit seen;
    seen = 1'b0;
    repeat (n) begin
      @(negedge Clk);
      if (Done !== 1'b0) seen = 1'b1;
    end
    chk(tag, 32'(seen), 32'd0);
  endtask

  logic [7:0] pairs[256];

  initial begin
    vectors     = 0;
    miscompares = 0;
    Rst_n = 1'b0;
    Start = 1'b0;
    A     = '0;
    B     = '0;

    // Reset state, observed before any clock edge.
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_p", 32'(P), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;

    // Largest operands.
    run_op("max_15x15", 4'd15, 4'd15);
    no_done("max_single_pulse", 1);

    // Zero operands.
    run_op("zero_a", 4'd0, 4'd9);
    run_op("zero_b", 4'd9, 4'd0);

    // Start while busy is ignored.
    @(negedge Clk);
    Start = 1'b1;
    A = 4'd5;
    B = 4'd3;
    push_exp(4'd5, 4'd3);
    @(posedge Clk);
    @(negedge Clk);
    chk("ignore_busy_high", 32'(Busy), 32'd1);
    A = 4'd7;
    B = 4'd7;
    @(posedge Clk);
    #1 Start = 1'b0;
    wait_done("ignore_start", exp_lat(4'd3), 1);
    no_done("ignore_no_extra_done", W + 3);
    chk("ignore_p_hold", 32'(P), 32'd15);

    // Asynchronous reset mid-operation.
    @(negedge Clk);
    Start = 1'b1;
    A = 4'd12;
    B = 4'd11;
    @(posedge Clk);
    #1 Start = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    #1 Rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_done", 32'(Done), 32'd0);
    chk("abort_p", 32'(P), 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;
    no_done("abort_no_done", W + 3);
    chk("abort_p_after", 32'(P), 32'd0);

    // Back-to-back with Start held high, second operands loaded in the Done cycle.
    @(negedge Clk);
    Start = 1'b1;
    A = 4'd3;
    B = 4'd6;
    push_exp(4'd3, 4'd6);
    @(posedge Clk);
    wait_done("b2b_first", exp_lat(4'd6), 0);
    A = 4'd14;
    B = 4'd13;
    push_exp(4'd14, 4'd13);
    wait_done("b2b_second", exp_lat(4'd13), 0);
    Start = 1'b0;

    // Randomized back-to-back chain.
    @(negedge Clk);
    Start = 1'b1;
    A = W'($urandom_range(0, (1 << W) - 1));
    B = W'($urandom_range(0, (1 << W) - 1));
    push_exp(A, B);
    @(posedge Clk);
    for (int k = 0; k < 20; k++) begin
      logic [W-1:0] bcur;
      bcur = B;
      wait_done("chain", exp_lat(bcur), 0);
      if (k == 19) begin
        Start = 1'b0;
      end else begin
        A = W'($urandom_range(0, (1 << W) - 1));
        B = W'($urandom_range(0, (1 << W) - 1));
        push_exp(A, B);
      end
    end

    // Exhaustive sweep in shuffled order with random idle gaps.
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      int j;
      logic [7:0] t;
      j = $urandom_range(0, i);
      t = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge Clk);
      run_op("sweep", pairs[i][7:4], pairs[i][3:0]);
    end

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
